// File: rtl/da_fir_seq.sv
// rtl/da_fir_seq.sv - bit-serial distributed-arithmetic FIR sequencer (DA_FIR_SAT_EN selects saturating output)
module da_fir_seq #(
  parameter int DATA_W = 12,
  parameter int TAPS   = 8,
  parameter int OPSIZE = 12,
  parameter int OUT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_sample,
  output logic              o_ready,
  output logic              o_rom_oe,
  output logic [TAPS-1:0]   o_rom_addr,
  input  logic [OPSIZE-1:0] i_rom_data,
  output logic              o_valid,
  output logic [OUT_W-1:0]  o_result,
  input  logic              i_ready
);

  localparam int ACC_W = OPSIZE + DATA_W;
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, COMPUTE, OUT} state_t;

  state_t                    state, state_nxt;
  logic [DATA_W-1:0]         taps [TAPS];
  logic [CNT_W-1:0]          bcnt;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   rom_ext;
  logic signed [ACC_W-1:0]   term;
  logic signed [ACC_W-1:0]   acc_nxt;
  logic signed [OUT_W-1:0]   result;
  logic signed [OUT_W-1:0]   res_nxt;
  logic                      last_bit;

  assign last_bit = (bcnt == CNT_W'(DATA_W - 1));
  assign o_result = result;

`ifdef DA_FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`endif

  // Partial-sum weighting: the sign bit's partial sum is subtracted, all others added
  always_comb begin
    rom_ext = {{(ACC_W-OPSIZE){i_rom_data[OPSIZE-1]}}, i_rom_data};
    term    = rom_ext <<< bcnt;
    acc_nxt = last_bit ? (acc - term) : (acc + term);
`ifdef DA_FIR_SAT_EN
    if (acc_nxt > MAX_V) begin
      res_nxt = MAX_V[OUT_W-1:0];
    end else if (acc_nxt < MIN_V) begin
      res_nxt = MIN_V[OUT_W-1:0];
    end else begin
      res_nxt = acc_nxt[OUT_W-1:0];
    end
`else
    res_nxt = acc_nxt[OUT_W-1:0];
`endif
  end

  // ROM address: bit b of every tap, only while computing
  always_comb begin
    o_rom_addr = '0;
    if (state == COMPUTE) begin
      for (int t = 0; t < TAPS; t++) begin
        o_rom_addr[t] = taps[t][bcnt];
      end
    end
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake/enable outputs; o_ready is masked while reset is held
  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    o_rom_oe  = 1'b0;
    case (state)
      IDLE: begin
        o_ready = ~i_rst;
        if (i_valid) state_nxt = COMPUTE;
      end
      COMPUTE: begin
        o_rom_oe = 1'b1;
        if (last_bit) state_nxt = OUT;
      end
      OUT: begin
        o_valid = 1'b1;
        if (i_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Delay line, bit counter, accumulator and held result
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int t = 0; t < TAPS; t++) begin
        taps[t] <= '0;
      end
      bcnt   <= '0;
      acc    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            taps[0] <= i_sample;
            for (int t = TAPS - 1; t > 0; t--) begin
              taps[t] <= taps[t-1];
            end
            bcnt <= '0;
            acc  <= '0;
          end
        end
        COMPUTE: begin
          acc  <= acc_nxt;
          bcnt <= bcnt + CNT_W'(1);
          if (last_bit) result <= res_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule
